fifo_rd_ctrl: RTL and testbench
===============================

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, memory address width; depth = 2^ADDR_WIDTH entries.
REQ-002 SHALL have parameter AE_LEVEL, default 1, almost-empty threshold in entries (0..2^ADDR_WIDTH).
REQ-003 SHALL have port r_clk  input  1  read-domain clock; the block uses one clock and all flops sample on its rising edge.
REQ-004 SHALL have port r_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port r_inc  input  1  read request.
REQ-006 SHALL have port rq2_w_ptr  input  ADDR_WIDTH+1  Gray write pointer, already two-flop synchronised into r_clk upstream.
REQ-007 SHALL have port r_addr  output  ADDR_WIDTH  memory read address.
REQ-008 SHALL have port r_gray_ptr  output  ADDR_WIDTH+1  registered Gray read pointer, sent to the write domain.
REQ-009 SHALL have port r_empty  output  1  registered empty flag.
REQ-010 SHALL have port r_almost_empty  output  1  registered level <= AE_LEVEL flag.
REQ-011 SHALL have port r_level  output  ADDR_WIDTH+1  registered occupancy as seen from the read side.
REQ-012 SHALL have port r_underflow  output  1  one-cycle read-while-empty pulse (see Configuration).

Function
REQ-013 SHALL hold an internal binary read pointer rbin, ADDR_WIDTH+1 bits, with r_addr = rbin[ADDR_WIDTH-1:0] taken directly from the register.
REQ-014 SHALL compute rd_en = r_inc & ~r_empty and rbin_next = rbin + rd_en, modulo 2^(ADDR_WIDTH+1).
REQ-015 SHALL register rbin <= rbin_next and r_gray_ptr <= rbin_next ^ (rbin_next >> 1) every cycle, so the Gray output changes one bit per read.
REQ-016 SHALL register r_empty <= (Gray(rbin_next) == rq2_w_ptr); the flag deasserts one cycle after rq2_w_ptr changes and asserts in the cycle after the final read.
REQ-017 SHALL convert rq2_w_ptr to binary wbin (XOR prefix from MSB) and register r_level <= wbin - rbin_next, modulo 2^(ADDR_WIDTH+1).
REQ-018 SHALL register r_almost_empty <= (wbin - rbin_next) <= AE_LEVEL.
REQ-019 SHALL ignore r_inc while r_empty=1: rbin, r_addr and r_gray_ptr hold.
REQ-020 SHALL wrap rbin from 2^(ADDR_WIDTH+1)-1 to 0 with no other side effect; r_addr wraps from 2^ADDR_WIDTH-1 to 0.
REQ-021 SHALL, when r_inc and a rq2_w_ptr change occur in the same cycle, use both the new rq2_w_ptr and the new rbin_next to compute the flags and r_level for the next cycle.
REQ-022 SHALL have a read latency of one cycle: r_addr advances on the edge after an accepted r_inc.

Reset
REQ-023 SHALL, on the r_clk edge with r_rst=1, set rbin=0, r_addr=0, r_gray_ptr=0, r_level=0, r_empty=1, r_almost_empty=1 and r_underflow=0.
REQ-024 SHALL give r_rst priority over r_inc and rq2_w_ptr, including a reset asserted mid-operation.
REQ-025 SHALL NOT reset asynchronously; outputs hold until the next r_clk edge.

Configuration
REQ-026 SHALL compile underflow detection only when macro FIFO_RD_UNDERFLOW_DETECT_EN is defined.
REQ-027 SHALL, with FIFO_RD_UNDERFLOW_DETECT_EN defined, register r_underflow <= r_inc & r_empty, giving a one-cycle pulse after each rejected read.
REQ-028 SHALL, without FIFO_RD_UNDERFLOW_DETECT_EN, keep the r_underflow port and tie it to 0 with no detection logic; all other behaviour is unchanged.

Verification (ADDR_WIDTH=3, AE_LEVEL=1)
REQ-029 SHALL cover: r_rst=1 for 2 cycles -> r_empty=1, r_almost_empty=1, r_addr=0, r_gray_ptr=0000, r_level=0.
REQ-030 SHALL cover: rq2_w_ptr=0110 (4 entries), then 4 r_inc cycles -> r_level 4,3,2,1,0; r_gray_ptr 0001,0011,0010,0110; r_addr 1..4; r_empty=1 one cycle after the 4th read; r_almost_empty=1 from level 1.
REQ-031 SHALL cover: 16 write/read pairs -> rbin wraps 1111->0000; r_gray_ptr 1000->0000; r_addr 7->0; r_empty correct throughout.
REQ-032 SHALL cover: r_empty=1 with r_inc=1 -> pointer holds; r_underflow=1 for exactly one cycle with the macro defined, and 0 without it.
REQ-033 SHALL cover: r_level=3 with r_rst=1 and r_inc=1 in the same cycle -> all reset values on the next edge, with no pointer increment.
REQ-034 SHALL cover: r_inc in the same cycle rq2_w_ptr goes 0000->0001 from empty -> read rejected; next cycle r_empty=0, r_level=1.

Source files
------------

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_rd_ctrl                                               |
// | Description : Read-side pointer and flag controller for an asynchronous  |
// |               FIFO. Keeps a binary read pointer, publishes it in Gray    |
// |               code to the write domain, and derives registered empty,    |
// |               almost-empty and occupancy from the synchronised Gray      |
// |               write pointer.                                             |
// | Option      : define FIFO_RD_UNDERFLOW_DETECT_EN to build the underflow   |
// |               pulse; otherwise r_underflow is tied to 0.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// Ports
//   r_clk          in   read-domain clock (rising edge)
//   r_rst          in   synchronous active-high reset
//   r_inc          in   read request
//   rq2_w_ptr      in   Gray write pointer, already synchronised to r_clk
//   r_addr         out  memory read address
//   r_gray_ptr     out  registered Gray read pointer to the write domain
//   r_empty        out  registered empty flag
//   r_almost_empty out  registered (level <= AE_LEVEL) flag
//   r_level        out  registered occupancy seen from the read side
//   r_underflow    out  one-cycle pulse after a read rejected while empty

module fifo_rd_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AE_LEVEL   = 1
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  r_inc,
   input  logic [ADDR_WIDTH:0]   rq2_w_ptr,
   output logic [ADDR_WIDTH-1:0] r_addr,
   output logic [ADDR_WIDTH:0]   r_gray_ptr,
   output logic                  r_empty,
   output logic                  r_almost_empty,
   output logic [ADDR_WIDTH:0]   r_level,
   output logic                  r_underflow
);

   // Threshold at pointer width; AE_LEVEL never exceeds 2^ADDR_WIDTH so it fits.
   localparam logic [ADDR_WIDTH:0] c_AE_LEVEL = (ADDR_WIDTH+1)'(AE_LEVEL);

   logic [ADDR_WIDTH:0] r_rbin;
   logic [ADDR_WIDTH:0] w_rbin_next;
   logic [ADDR_WIDTH:0] w_gray_next;
   logic [ADDR_WIDTH:0] w_wbin;
   logic [ADDR_WIDTH:0] w_level_next;
   logic                w_rd_en;

   // A read is only accepted while the FIFO is known to hold data.
   assign w_rd_en      = r_inc & ~r_empty;
   assign w_rbin_next  = r_rbin + {{ADDR_WIDTH{1'b0}}, w_rd_en};
   assign w_gray_next  = w_rbin_next ^ (w_rbin_next >> 1);

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_gray2bin
      assign w_wbin[i] = ^rq2_w_ptr[ADDR_WIDTH:i];
   end

   // Flags use the post-read pointer so a read and a write landing in the
   // same cycle are both reflected on the next edge.
   assign w_level_next = w_wbin - w_rbin_next;

   assign r_addr = r_rbin[ADDR_WIDTH-1:0];

   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_rbin         <= '0;
         r_gray_ptr     <= '0;
         r_level        <= '0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
      end else begin
         r_rbin         <= w_rbin_next;
         r_gray_ptr     <= w_gray_next;
         r_level        <= w_level_next;
         r_empty        <= (w_gray_next == rq2_w_ptr);
         r_almost_empty <= (w_level_next <= c_AE_LEVEL);
      end
   end

`ifdef FIFO_RD_UNDERFLOW_DETECT_EN
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_underflow <= 1'b0;
      end else begin
         r_underflow <= r_inc & r_empty;
      end
   end
`else
   assign r_underflow = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_rd_ctrl                                            |
// | Description : Directed, table-driven bench for fifo_rd_ctrl with         |
// |               ADDR_WIDTH=3, AE_LEVEL=1, plus pointer-wrap and            |
// |               simultaneous read/write sequences.                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

module tb_fifo_rd_ctrl;

`ifdef FIFO_RD_UNDERFLOW_DETECT_EN
   localparam logic c_UF_EN = 1'b1;
`else
   localparam logic c_UF_EN = 1'b0;
`endif

   logic       r_clk = 1'b0;
   logic       r_rst;
   logic       r_inc;
   logic [3:0] rq2_w_ptr;
   logic [2:0] r_addr;
   logic [3:0] r_gray_ptr;
   logic       r_empty;
   logic       r_almost_empty;
   logic [3:0] r_level;
   logic       r_underflow;

   int checks   = 0;
   int failures = 0;

   fifo_rd_ctrl #(.ADDR_WIDTH(3), .AE_LEVEL(1)) u_dut (
      .r_clk          (r_clk),
      .r_rst          (r_rst),
      .r_inc          (r_inc),
      .rq2_w_ptr      (rq2_w_ptr),
      .r_addr         (r_addr),
      .r_gray_ptr     (r_gray_ptr),
      .r_empty        (r_empty),
      .r_almost_empty (r_almost_empty),
      .r_level        (r_level),
      .r_underflow    (r_underflow)
   );

   always #5 r_clk = ~r_clk;

   // uf holds the pulse expected when underflow detection is built in.
   typedef struct packed {
      logic       rst;
      logic       inc;
      logic [3:0] w;
      logic [2:0] addr;
      logic [3:0] gray;
      logic       empty;
      logic       ae;
      logic [3:0] level;
      logic       uf;
   } vec_t;

   localparam int c_NVEC = 17;
   vec_t vecs [c_NVEC];

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic rst, input logic inc, input logic [3:0] w);
      @(negedge r_clk);
      r_rst     = rst;
      r_inc     = inc;
      rq2_w_ptr = w;
      @(posedge r_clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [2:0] addr, input logic [3:0] gray,
                          input logic empty, input logic ae, input logic [3:0] level,
                          input logic uf);
      chk({tag, ".addr"},  {5'd0, r_addr},         {5'd0, addr});
      chk({tag, ".gray"},  {4'd0, r_gray_ptr},     {4'd0, gray});
      chk({tag, ".empty"}, {7'd0, r_empty},        {7'd0, empty});
      chk({tag, ".ae"},    {7'd0, r_almost_empty}, {7'd0, ae});
      chk({tag, ".level"}, {4'd0, r_level},        {4'd0, level});
      chk({tag, ".uf"},    {7'd0, r_underflow},    {7'd0, uf & c_UF_EN});
   endtask

   initial begin
      //             rst   inc   w        addr  gray     emp   ae    level  uf
      vecs[0]  = '{1'b1, 1'b0, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0}; // reset
      vecs[1]  = '{1'b1, 1'b0, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0}; // reset
      vecs[2]  = '{1'b0, 1'b0, 4'b0110, 3'd0, 4'b0000, 1'b0, 1'b0, 4'd4, 1'b0}; // 4 written
      vecs[3]  = '{1'b0, 1'b1, 4'b0110, 3'd1, 4'b0001, 1'b0, 1'b0, 4'd3, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 4'b0110, 3'd2, 4'b0011, 1'b0, 1'b0, 4'd2, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'b0110, 3'd3, 4'b0010, 1'b0, 1'b1, 4'd1, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 4'b0110, 3'd4, 4'b0110, 1'b1, 1'b1, 4'd0, 1'b0}; // last read
      vecs[7]  = '{1'b0, 1'b1, 4'b0110, 3'd4, 4'b0110, 1'b1, 1'b1, 4'd0, 1'b1}; // underflow
      vecs[8]  = '{1'b0, 1'b0, 4'b0110, 3'd4, 4'b0110, 1'b1, 1'b1, 4'd0, 1'b0}; // pulse ends
      vecs[9]  = '{1'b0, 1'b1, 4'b0111, 3'd4, 4'b0110, 1'b0, 1'b1, 4'd1, 1'b1}; // read+write when empty
      vecs[10] = '{1'b0, 1'b0, 4'b0111, 3'd4, 4'b0110, 1'b0, 1'b1, 4'd1, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 4'b0100, 3'd4, 4'b0110, 1'b0, 1'b0, 4'd3, 1'b0}; // level 3
      vecs[12] = '{1'b1, 1'b1, 4'b0100, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b0}; // reset beats read
      vecs[13] = '{1'b0, 1'b1, 4'b0000, 3'd0, 4'b0000, 1'b1, 1'b1, 4'd0, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 4'b0001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b1}; // 0000->0001 with read
      vecs[15] = '{1'b0, 1'b0, 4'b0001, 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 4'b0001, 3'd1, 4'b0001, 1'b1, 1'b1, 4'd0, 1'b0};

      r_rst     = 1'b1;
      r_inc     = 1'b0;
      rq2_w_ptr = 4'b0000;

      for (int v = 0; v < c_NVEC; v++) begin
         step(vecs[v].rst, vecs[v].inc, vecs[v].w);
         chk_all($sformatf("vec%0d", v), vecs[v].addr, vecs[v].gray, vecs[v].empty,
                 vecs[v].ae, vecs[v].level, vecs[v].uf);
      end

      // Sixteen write/read pairs starting from a clean reset: the binary
      // pointer walks all the way round back to zero.
      step(1'b1, 1'b0, 4'b0000);
      for (int k = 0; k < 16; k++) begin
         logic [3:0] nb;
         nb = 4'(k + 1);
         step(1'b0, 1'b0, to_gray(nb));
         chk($sformatf("wrap%0d.empty_w", k), {7'd0, r_empty}, 8'd0);
         chk($sformatf("wrap%0d.level_w", k), {4'd0, r_level}, 8'd1);
         step(1'b0, 1'b1, to_gray(nb));
         chk($sformatf("wrap%0d.addr", k),    {5'd0, r_addr},     {5'd0, nb[2:0]});
         chk($sformatf("wrap%0d.gray", k),    {4'd0, r_gray_ptr}, {4'd0, to_gray(nb)});
         chk($sformatf("wrap%0d.empty_r", k), {7'd0, r_empty},    8'd1);
      end

      // Read and write in the same cycle: occupancy stays at one.
      step(1'b0, 1'b0, 4'b0001);
      chk_all("rw_pre", 3'd0, 4'b0000, 1'b0, 1'b1, 4'd1, 1'b0);
      step(1'b0, 1'b1, 4'b0011);
      chk_all("rw_same", 3'd1, 4'b0001, 1'b0, 1'b1, 4'd1, 1'b0);
      step(1'b0, 1'b0, 4'b0011);
      chk_all("rw_post", 3'd1, 4'b0001, 1'b0, 1'b1, 4'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
